gates4a_sweep_ctrl: RTL

Sequencer and self-checker for the 4-input reduction-gate datapath (gates4a: 4-bit input a, 6-bit output y).
- On start, drives all 16 input vectors in ascending order, holding each for a programmable number of cycles.
- Samples y at the end of each hold and compares it against an internal golden model.
- Reports error count, first failing vector, failing-bit mask and pass/done status.
- Sits between a board-level control (button/switch or bench) and a gates4a instance, replacing the hand-written exhaustive stimulus sequence with a synthesizable one.

---
 rtl/gates4a_sweep_ctrl_pkg.sv | 25 ++
 rtl/gates4a_sweep_ctrl_if.sv | 28 ++
 rtl/gates4a_expect.sv | 19 +
 rtl/gates4a_sweep_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/gates4a_sweep_ctrl_pkg.sv
// Shared definitions for gates4a sweep controllers and benches:
// state encoding, datapath widths and y bit positions.
package gates4a_sweep_ctrl_pkg;

  localparam int unsigned A_W   = 4;
  localparam int unsigned Y_W   = 6;
  localparam int unsigned ERR_W = 5;

  // Bit positions of each reduction result within y
  localparam int unsigned Y_AND  = 0;
  localparam int unsigned Y_NAND = 1;
  localparam int unsigned Y_OR   = 2;
  localparam int unsigned Y_NOR  = 3;
  localparam int unsigned Y_XOR  = 4;
  localparam int unsigned Y_XNOR = 5;

  localparam logic [A_W-1:0] A_LAST = A_W'(15);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gates4a_sweep_ctrl_if.sv
// Control/result bundle between a board-level controller (master) and the
// sweep controller (slave), including the gates4a stimulus/response pair.
interface gates4a_sweep_ctrl_if;
  import gates4a_sweep_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic [Y_W-1:0]   y_in;
  logic [A_W-1:0]   a_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [A_W-1:0]   first_fail;
  logic             fail_valid;
  logic [Y_W-1:0]   fail_mask;

  modport master (
    output start, abort, y_in,
    input  a_out, busy, done, pass, err_count, first_fail, fail_valid, fail_mask
  );

  modport slave (
    input  start, abort, y_in,
    output a_out, busy, done, pass, err_count, first_fail, fail_valid, fail_mask
  );

endinterface

// File: rtl/gates4a_expect.sv
// Golden model of the gates4a datapath: the six 4-input reductions of a.
module gates4a_expect
  import gates4a_sweep_ctrl_pkg::*;
(
  input  logic [A_W-1:0] a,
  output logic [Y_W-1:0] y
);

  always_comb begin
    y         = '0;
    y[Y_AND]  = &a;
    y[Y_NAND] = ~&a;
    y[Y_OR]   = |a;
    y[Y_NOR]  = ~|a;
    y[Y_XOR]  = ^a;
    y[Y_XNOR] = ~^a;
  end

endmodule

// File: rtl/gates4a_sweep_ctrl.sv
// Exhaustive sweep sequencer for gates4a: steps a_out through 0..15, holding
// each vector HOLD_CYCLES cycles, and checks y_in against the golden model.
module gates4a_sweep_ctrl
  import gates4a_sweep_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                clr,
  gates4a_sweep_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [A_W-1:0]   first_q, first_d;
  logic             fvalid_q, fvalid_d;
  logic [Y_W-1:0]   mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [Y_W-1:0]   exp_y;
  logic [Y_W-1:0]   diff;
  logic             hold_end;

  gates4a_expect u_expect (
    .a (a_q),
    .y (exp_y)
  );

  assign diff     = bus.y_in ^ exp_y;
  assign hold_end = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      first_q  <= '0;
      fvalid_q <= 1'b0;
      mask_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      first_q  <= first_d;
      fvalid_q <= fvalid_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  // Next-state, counters and result accumulation
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    first_d  = first_q;
    fvalid_d = fvalid_q;
    mask_d   = mask_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          a_d      = '0;
          cnt_d    = '0;
          err_d    = '0;
          first_d  = '0;
          fvalid_d = 1'b0;
          mask_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          // Partial results are kept for inspection after an abort
          state_d = S_IDLE;
          a_d     = '0;
          cnt_d   = '0;
        end else if (hold_end) begin
          if (|diff) begin
            err_d  = err_q + ERR_W'(1);
            mask_d = mask_q | diff;
            if (!fvalid_q) begin
              first_d  = a_q;
              fvalid_d = 1'b1;
            end
          end
          cnt_d = '0;
          if (a_q == A_LAST) begin
            state_d = S_DONE;
          end else begin
            a_d = a_q + A_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        a_d     = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  assign bus.a_out      = a_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = first_q;
  assign bus.fail_valid = fvalid_q;
  assign bus.fail_mask  = mask_q;

endmodule
